// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS integer core: multiply FSM encoding,
// datapath width constants and the SPECIAL-opcode funct codes that the
// decoder uses to steer the HI/LO multiply unit.
package mips_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int MULT_ITERS = DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } mult_state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;

endpackage

// File: rtl/mult_hilo8_dp.sv
// Radix-2 shift-and-add datapath: operand magnitudes, accumulator, shift
// registers and the final sign fix-up. Control comes from mult_hilo8.
module mult_hilo8_dp
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_op,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    // Magnitude of a two's-complement operand; the most negative value maps
    // onto itself, which is still correct when read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic            sgn);
        return (sgn && v[WIDTH-1]) ? ('0 - v) : v;
    endfunction

    // Load magnitudes on acceptance, then one conditional add and shift per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, mag(a, signed_op)};
            mplier <= mag(b, signed_op);
            acc    <= '0;
            neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Restore the sign of the result from the unsigned magnitude product.
    always_comb begin
        product = neg ? ('0 - acc) : acc;
    end

endmodule

// File: rtl/mult_hilo8.sv
// Sequential multiply unit with architectural HI/LO registers
// (MULT/MULTU/MTHI/MTLO). Owns the FSM, iteration counter and HI/LO.
//
// Handshake: start is a request that is accepted only on an edge where the
// unit is IDLE (busy low). Requests while busy are dropped, never queued.
// mthi/mtlo are accepted under the same rule, except that start takes
// priority over them in IDLE.
module mult_hilo8
    import mips_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic             signed_op,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    mult_state_t          state;
    mult_state_t          state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 load;
    logic                 step;
    logic [2*WIDTH-1:0]   product;

    mult_hilo8_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .product   (product)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Iteration counter: cleared on acceptance, advanced once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // HI/LO: product written on leaving FINISH; moves only when idle without start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_FINISH) begin
            hi <= product[2*WIDTH-1:WIDTH];
            lo <= product[WIDTH-1:0];
        end else if (state == ST_IDLE && !start) begin
            if (mthi) begin
                hi <= wdata;
            end
            if (mtlo) begin
                lo <= wdata;
            end
        end
    end

    // One-cycle completion pulse coinciding with the HI/LO product update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state == ST_FINISH);
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_hilo8.sv
// Bench for mult_hilo8: a cycle-level reference model built from the
// acceptance/latency rules, a per-cycle output compare, and directed
// vectors with hand-computed products.
module tb_mult_hilo8;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic       signed_op;
    logic       mthi;
    logic       mtlo;
    logic [7:0] wdata;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    mult_hilo8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .start     (start),
        .signed_op (signed_op),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_product(input logic [7:0] x,
                                                input logic [7:0] y,
                                                input logic       s);
        int xi;
        int yi;
        int p;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        p  = xi * yi;
        return p[15:0];
    endfunction

    int          cyc;
    int          m_done_at;
    logic [15:0] m_prod;
    logic [7:0]  m_hi;
    logic [7:0]  m_lo;
    logic        m_busy;
    logic        m_done;

    // A multiply accepted at edge N delivers its product at edge N+9; the
    // unit ignores every request until then.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi      = 8'h00;
            m_lo      = 8'h00;
            m_busy    = 1'b0;
            m_done    = 1'b0;
            m_done_at = 0;
            m_prod    = 16'h0000;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (m_busy) begin
                if (cyc == m_done_at) begin
                    m_hi   = m_prod[15:8];
                    m_lo   = m_prod[7:0];
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                m_busy    = 1'b1;
                m_done_at = cyc + 9;
                m_prod    = ref_product(a, b, signed_op);
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks++;
        if ({hi, lo, busy, done} !== {m_hi, m_lo, m_busy, m_done}) begin
            failures++;
            $display("FAIL cycle_compare t=%0t hi/lo/busy/done actual=%h/%h/%b/%b required=%h/%h/%b/%b",
                     $time, hi, lo, busy, done, m_hi, m_lo, m_busy, m_done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
    endtask

    // Waits for done, counting negedges after the acceptance edge. An
    // optional disturbance (start + moves) is driven at a given count.
    task automatic wait_done(input int disturb_at, output int n, output logic got);
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            #1;
            clear_inputs();
            if (n == disturb_at) begin
                a         = 8'hFF;
                b         = 8'hFF;
                signed_op = 1'b1;
                start     = 1'b1;
                mthi      = 1'b1;
                mtlo      = 1'b1;
                wdata     = 8'h33;
            end
        end
    endtask

    task automatic run_mult(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                            input logic [15:0] exp, input int disturb_at, input string name);
        int   n;
        logic got;
        @(negedge clk);
        #1;
        a         = ta;
        b         = tb_v;
        signed_op = ts;
        start     = 1'b1;
        @(negedge clk);
        #1;
        clear_inputs();
        a = ~ta;
        b = ~tb_v;
        wait_done(disturb_at, n, got);
        chk({name, "_latency"}, 32'(n), 32'd9);
        chk({name, "_product"}, {16'h0, hi, lo}, {16'h0, exp});
    endtask

    task automatic move(input logic h, input logic l, input logic [7:0] d);
        @(negedge clk);
        #1;
        mthi  = h;
        mtlo  = l;
        wdata = d;
        @(negedge clk);
        #1;
        clear_inputs();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   n;
        int   dcount;
        logic got;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        signed_op = 1'b0;
        wdata     = 8'h00;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {22'h0, hi, lo, busy, done}, 32'h0);
        #1;
        rst_n = 1'b1;

        run_mult(8'h07, 8'h06, 1'b0, 16'h002A, -1, "multu_7x6");
        run_mult(8'hFF, 8'hFF, 1'b0, 16'hFE01, -1, "multu_ffxff");
        run_mult(8'hFF, 8'hFF, 1'b1, 16'h0001, -1, "mult_m1xm1");
        run_mult(8'h80, 8'h80, 1'b1, 16'h4000, -1, "mult_m128xm128");
        run_mult(8'h80, 8'h01, 1'b1, 16'hFF80, -1, "mult_m128x1");
        run_mult(8'h07, 8'hFA, 1'b1, 16'hFFD6, -1, "mult_7xm6");
        run_mult(8'h80, 8'h80, 1'b0, 16'h4000, -1, "multu_80x80");

        move(1'b1, 1'b0, 8'h5A);
        chk("mthi", {24'h0, hi}, 32'h5A);
        move(1'b0, 1'b1, 8'hA5);
        chk("mthi_mtlo", {16'h0, hi, lo}, 32'h5AA5);
        move(1'b1, 1'b1, 8'hC3);
        chk("mthi_mtlo_both", {16'h0, hi, lo}, 32'hC3C3);
        move(1'b1, 1'b0, 8'h5A);
        move(1'b0, 1'b1, 8'hA5);

        // start together with mthi: the move is dropped.
        @(negedge clk);
        #1;
        a         = 8'h03;
        b         = 8'h05;
        signed_op = 1'b0;
        start     = 1'b1;
        mthi      = 1'b1;
        wdata     = 8'h11;
        @(negedge clk);
        chk("start_wins_hi", {16'h0, hi, lo}, 32'h5AA5);
        #1;
        clear_inputs();
        wait_done(-1, n, got);
        chk("start_wins_latency", 32'(n), 32'd9);
        chk("start_wins_product", {16'h0, hi, lo}, 32'h000F);

        // start (and moves) while busy are ignored.
        run_mult(8'h07, 8'h06, 1'b0, 16'h002A, 3, "busy_start_ignored");
        @(negedge clk);
        chk("idle_after_ignored", {31'h0, busy}, 32'h0);

        // Reset in the middle of RUN aborts the multiply.
        @(negedge clk);
        #1;
        a     = 8'h09;
        b     = 8'h09;
        start = 1'b1;
        @(negedge clk);
        #1;
        clear_inputs();
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_hilo", {16'h0, hi, lo}, 32'h0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        chk("abort_hilo_hold", {16'h0, hi, lo}, 32'h0);

        // Unit is usable again after the abort.
        run_mult(8'h10, 8'h10, 1'b0, 16'h0100, -1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
